// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the dual-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_PORTS = 8;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of (req & mask) at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Doubling the vector turns the wrap-around search into a plain shift.
    assign cand = req & mask;
    assign dbl  = {cand, cand} >> start;
    assign rot  = dbl[N-1:0];

    always_comb begin
        valid = 1'b0;
        sum   = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, start} + (IW+1)'(k);
            end
        end
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
    end

    assign idx = IW'(sum);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            onehot[i] = valid && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates N requesters onto a 1RW + 1R memory: winner A takes port 0,
// a following reader B takes port 1; read data returns one cycle later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 3,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fixed_prio,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             web,
    input  logic [NUM_PORTS*NUM_WMASKS-1:0]  wmask,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  din,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
    output logic                             csb0,
    output logic                             web0,
    output logic [NUM_WMASKS-1:0]            wmask0,
    output logic [ADDR_WIDTH-1:0]            addr0,
    output logic [DATA_WIDTH-1:0]            din0,
    input  logic [DATA_WIDTH-1:0]            dout0,
    output logic                             csb1,
    output logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [DATA_WIDTH-1:0]            dout1
);

    localparam int unsigned IW = ptr_width(NUM_PORTS);

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        start_a;
    logic [IW-1:0]        nxt_a;
    logic [NUM_PORTS-1:0] a_oh, b_oh;
    logic [IW-1:0]        a_idx, b_idx;
    logic                 a_valid, b_valid;
    logic                 a_en, b_en;
    logic [NUM_PORTS-1:0] rvalid_q;
    logic [NUM_PORTS-1:0] sel_q;

    assign start_a = fixed_prio ? '0 : rr_ptr;
    assign nxt_a   = (a_idx == IW'(NUM_PORTS - 1)) ? '0 : a_idx + 1'b1;

    rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_a (
        .req    (req),
        .mask   ({NUM_PORTS{1'b1}}),
        .start  (start_a),
        .onehot (a_oh),
        .idx    (a_idx),
        .valid  (a_valid)
    );

    // B continues the same search past A; requesters before A in the order are idle.
    rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_b (
        .req    (req & {NUM_PORTS{a_valid}}),
        .mask   (web & ~a_oh),
        .start  (nxt_a),
        .onehot (b_oh),
        .idx    (b_idx),
        .valid  (b_valid)
    );

    assign a_en = a_valid && !reset;
    assign b_en = b_valid && !reset;
    assign gnt  = reset ? '0 : (a_oh | b_oh);

    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (a_en && (a_idx == IW'(i))) begin
                csb0   = 1'b0;
                web0   = web[i];
                wmask0 = wmask[i*NUM_WMASKS +: NUM_WMASKS];
                addr0  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                din0   = din[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (b_en && (b_idx == IW'(i))) begin
                csb1  = 1'b0;
                addr1 = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Read return tracking; sel_q marks requesters served by port 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            rvalid_q <= '0;
            sel_q    <= '0;
        end else begin
            if (a_valid && !fixed_prio) begin
                rr_ptr <= nxt_a;
            end
            rvalid_q <= (a_oh & web) | b_oh;
            sel_q    <= b_oh;
        end
    end

    // Gating with reset drops a read that was granted just before reset.
    assign rvalid = reset ? '0 : rvalid_q;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (rvalid[i]) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = sel_q[i] ? dout1 : dout0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized check of mem_port_arbiter against a search-order reference model.
module tb_mem_port_arbiter;

    localparam int NP = 3;
    localparam int MW = 4;
    localparam int DW = 32;
    localparam int AW = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             fixed_prio;
    logic [NP-1:0]    req, web;
    logic [NP*MW-1:0] wmask;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] din;
    logic [NP-1:0]    gnt, rvalid;
    logic [NP*DW-1:0] rdata;
    logic             csb0, web0, csb1;
    logic [MW-1:0]    wmask0;
    logic [AW-1:0]    addr0, addr1;
    logic [DW-1:0]    din0, dout0, dout1;

    int n_vec = 0;
    int n_err = 0;

    int            m_rr = 0;
    logic [NP-1:0] m_rv = '0;
    logic [NP-1:0] m_sel = '0;
    logic [NP-1:0] last_eg = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS(NP), .NUM_WMASKS(MW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .fixed_prio(fixed_prio),
        .req(req), .web(web), .wmask(wmask), .addr(addr), .din(din),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational and returned-read outputs, then advance the model.
    task automatic cycle(input string tag, input bit chk_g, input logic [NP-1:0] want_g);
        int a, b, oa, st, j;
        logic [NP-1:0] eg;
        logic [DW-1:0] er;
        dout0 = $urandom;
        dout1 = $urandom;
        #3;
        a = -1; b = -1; oa = 0;
        if (!reset) begin
            st = fixed_prio ? 0 : m_rr;
            for (int k = 0; k < NP; k++) begin
                j = (st + k) % NP;
                if (a < 0 && req[j]) begin a = j; oa = k; end
            end
            if (a >= 0) begin
                for (int k = oa + 1; k < NP; k++) begin
                    j = (st + k) % NP;
                    if (b < 0 && req[j] && web[j]) b = j;
                end
            end
        end
        eg = '0;
        if (a >= 0) eg[a] = 1'b1;
        if (b >= 0) eg[b] = 1'b1;

        chk({tag, ":gnt"}, 64'(gnt), 64'(eg));
        if (chk_g) chk({tag, ":gnt_const"}, 64'(gnt), 64'(want_g));
        chk({tag, ":csb0"}, 64'(csb0), 64'(a < 0));
        chk({tag, ":web0"}, 64'(web0), (a < 0) ? 64'd1 : 64'(web[a]));
        chk({tag, ":wmask0"}, 64'(wmask0), (a < 0) ? 64'd0 : 64'(wmask[a*MW +: MW]));
        chk({tag, ":addr0"}, 64'(addr0), (a < 0) ? 64'd0 : 64'(addr[a*AW +: AW]));
        chk({tag, ":din0"}, 64'(din0), (a < 0) ? 64'd0 : 64'(din[a*DW +: DW]));
        chk({tag, ":csb1"}, 64'(csb1), 64'(b < 0));
        chk({tag, ":addr1"}, 64'(addr1), (b < 0) ? 64'd0 : 64'(addr[b*AW +: AW]));
        chk({tag, ":rvalid"}, 64'(rvalid), reset ? 64'd0 : 64'(m_rv));
        for (int i = 0; i < NP; i++) begin
            er = (!reset && m_rv[i]) ? (m_sel[i] ? dout1 : dout0) : '0;
            chk($sformatf("%s:rdata%0d", tag, i), 64'(rdata[i*DW +: DW]), 64'(er));
        end

        if (reset) begin
            m_rr = 0; m_rv = '0; m_sel = '0;
        end else begin
            if (a >= 0 && !fixed_prio) m_rr = (a + 1) % NP;
            m_rv = '0; m_sel = '0;
            if (a >= 0 && web[a]) m_rv[a] = 1'b1;
            if (b >= 0) begin m_rv[b] = 1'b1; m_sel[b] = 1'b1; end
        end
        last_eg = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(input int i);
        web[i]            = $urandom_range(0, 1) == 1;
        wmask[i*MW +: MW] = MW'($urandom);
        addr[i*AW +: AW]  = AW'($urandom);
        din[i*DW +: DW]   = $urandom;
    endtask

    initial begin
        reset = 1'b1; fixed_prio = 1'b0;
        req = '1; web = '1;
        wmask = '0; addr = '0; din = '0;
        dout0 = '0; dout1 = '0;
        for (int i = 0; i < NP; i++) rand_fields(i);
        web = '1;
        @(posedge clk);
        #1;
        cycle("rst_a", 1'b1, 3'b000);
        cycle("rst_b", 1'b1, 3'b000);

        reset = 1'b0;
        cycle("all_rd", 1'b1, 3'b011);
        req = '0;
        cycle("idle", 1'b1, 3'b000);

        reset = 1'b1;
        cycle("rst_c", 1'b1, 3'b000);
        reset = 1'b0; req = 3'b101; web = 3'b110;
        cycle("wr_rd", 1'b1, 3'b101);
        req = '0;
        cycle("wr_rd_ret", 1'b1, 3'b000);

        reset = 1'b1;
        cycle("rst_d", 1'b1, 3'b000);
        reset = 1'b0; req = 3'b111; web = 3'b000;
        cycle("wr_rot0", 1'b1, 3'b001);
        cycle("wr_rot1", 1'b1, 3'b010);
        cycle("wr_rot2", 1'b1, 3'b100);

        fixed_prio = 1'b1; req = 3'b110; web = 3'b111;
        cycle("fix0", 1'b1, 3'b110);
        cycle("fix1", 1'b1, 3'b110);
        cycle("fix2", 1'b1, 3'b110);

        fixed_prio = 1'b0; req = 3'b111;
        cycle("pre_rst", 1'b0, 3'b000);
        reset = 1'b1;
        cycle("rst_drop", 1'b1, 3'b000);
        reset = 1'b0;
        cycle("post_rst", 1'b0, 3'b000);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NP; i++) begin
                if (last_eg[i] || !req[i]) begin
                    req[i] = $urandom_range(0, 3) != 0;
                    rand_fields(i);
                end
            end
            if ($urandom_range(0, 9) == 0) fixed_prio = ~fixed_prio;
            reset = ($urandom_range(0, 39) == 0);
            cycle("rand", 1'b0, 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
